tft_touch_reader: RTL
=====================

Name: tft_touch_reader

Overview:
- SPI master for the AD7873/ADS7846-class resistive touch controller on the TFT board.
- Periodically converts X and Y while the pen is down, then scales the raw 12-bit results to screen pixel coordinates.
- Drives the touch_x/touch_y inputs of the TFT display driver.
- Runs entirely in the tft_clk domain.

Parameters:
- X_RES, 480, screen width in pixels; touch_x output range is 0..X_RES-1.
- Y_RES, 272, screen height in pixels; touch_y output range is 0..Y_RES-1.
- SCLK_DIV, 4, spi_sclk half-period in tft_clk cycles (min 2).
- SAMPLE_PERIOD, 90000, tft_clk cycles between conversion attempts (min 16).
- X_INVERT, 0, if 1 use 4095-raw_x before scaling.
- Y_INVERT, 0, if 1 use 4095-raw_y before scaling.

Ports:
- tft_clk  in  1  clock
- rstb  in  1  reset, synchronous, active-low
- penirq_n  in  1  pen-down from controller, asynchronous, active-low
- spi_miso  in  1  controller DOUT
- spi_cs_n  out  1  controller chip select, active-low
- spi_sclk  out  1  SPI clock, idle low
- spi_mosi  out  1  controller DIN
- touch_x  out  12  scaled X coordinate, zero-extended
- touch_y  out  12  scaled Y coordinate, zero-extended
- touch_valid  out  1  one-cycle pulse when touch_x/touch_y update
- touch_active  out  1  level, high while the last completed frame saw pen down

Behaviour:
- Reset (rstb low at a tft_clk edge), all outputs registered:
  - spi_cs_n=1, spi_sclk=0, spi_mosi=0, touch_x=0, touch_y=0, touch_valid=0, touch_active=0.
  - FSM goes to IDLE, sample timer=0, shift registers cleared.
  - Reset mid-frame aborts immediately: spi_cs_n is high on the next edge.
- penirq_n passes through a 2-flop synchronizer; pen_down = ~synced value. It is sampled only in IDLE and DONE.
- IDLE: timer counts up each cycle. At timer==SAMPLE_PERIOD-1:
  - timer clears.
  - If pen_down, go to SETUP; else stay in IDLE with touch_active=0.
- SETUP: spi_cs_n=0, spi_mosi=first command bit, spi_sclk low. Hold SCLK_DIV cycles, then go to SHIFT.
- SHIFT: 48 SCLK periods; each level lasts SCLK_DIV tft_clk cycles.
  - Periods 1-8: command 0xD0 (X, 12-bit, differential, PD=00), MSB first.
  - Periods 9-24: read X.
  - Periods 25-32: command 0x90 (Y).
  - Periods 33-48: read Y.
  - spi_mosi changes on the tft_clk edge that drives spi_sclk low. It is 0 outside command periods.
  - spi_miso is sampled on the tft_clk edge that drives spi_sclk high.
  - During each 16-period read, samples shift left into a 16-bit register. raw = reg[14:3] (first sample is the busy bit; last 3 are trailing zeros).
  - After the 48th falling edge, go to HOLD.
- HOLD: spi_sclk low, spi_cs_n still 0 for SCLK_DIV cycles. Then spi_cs_n=1 and go to DONE.
- Total frame is 98*SCLK_DIV cycles from spi_cs_n fall to rise (392 at default).
- DONE (1 cycle), evaluate pen_down:
  - If pen_down:
    - touch_x = (rx*X_RES)>>12 and touch_y = (ry*Y_RES)>>12, where rx/ry are raw values after optional inversion. Use a full-width product (12-bit by parameter width), no rounding.
    - touch_valid=1 for exactly this one cycle; touch_active=1.
  - Else: outputs hold, touch_active=0, no pulse.
  - Then return to IDLE with timer=0.
- penirq_n toggling during SETUP/SHIFT/HOLD is ignored (the controller pulls it during conversion).
- touch_x/touch_y change only in DONE. They are stable between updates, so the display driver can read them asynchronously to frame timing.

Test Plan:
- Reset with penirq_n=1, SAMPLE_PERIOD=32, run 500 cycles -> spi_cs_n stays 1, spi_sclk stays 0, touch_valid never pulses, touch_x=touch_y=0.
- penirq_n=0; slave model returns raw_x=0x800, raw_y=0x400 -> MOSI bytes 0xD0 then 0x90 captured on sclk rising edges; spi_cs_n low for exactly 392 cycles; touch_x=240, touch_y=68; one touch_valid pulse; touch_active=1.
- Slave returns raw 0xFFF/0xFFF -> touch_x=479, touch_y=271. Raw 0x000/0x000 -> 0, 0.
- X_INVERT=1, Y_INVERT=1, raw_x=0x000, raw_y=0xFFF -> touch_x=479, touch_y=0.
- Release penirq_n mid-SHIFT -> frame completes all 48 SCLK periods; no touch_valid; touch_x/touch_y keep previous values (240, 68); touch_active falls in DONE.
- Assert rstb=0 during read-X phase -> next edge: spi_cs_n=1, spi_sclk=0, outputs zero. After release, first frame starts only after SAMPLE_PERIOD cycles with pen down.

Source files
------------

// File: rtl/tft_touch_reader_if.sv
// Signal bundle between the touch reader, the touch controller and the display driver.
// The master modport is the reader's side; the slave modport is the controller/board side.
interface tft_touch_reader_if;
  logic        penirq_n;
  logic        spi_miso;
  logic        spi_cs_n;
  logic        spi_sclk;
  logic        spi_mosi;
  logic [11:0] touch_x;
  logic [11:0] touch_y;
  logic        touch_valid;
  logic        touch_active;

  modport master (
    input  penirq_n, spi_miso,
    output spi_cs_n, spi_sclk, spi_mosi, touch_x, touch_y, touch_valid, touch_active
  );

  modport slave (
    output penirq_n, spi_miso,
    input  spi_cs_n, spi_sclk, spi_mosi, touch_x, touch_y, touch_valid, touch_active
  );
endinterface

// File: rtl/tft_touch_reader.sv
// SPI master for an ADS7846-class resistive touch controller: periodically reads X/Y
// while the pen is down and scales the raw 12-bit results to screen pixel coordinates.
module tft_touch_reader #(
  parameter int X_RES         = 480,
  parameter int Y_RES         = 272,
  parameter int SCLK_DIV      = 4,
  parameter int SAMPLE_PERIOD = 90000,
  parameter int X_INVERT      = 0,
  parameter int Y_INVERT      = 0
) (
  input logic                tft_clk,
  input logic                rstb,
  tft_touch_reader_if.master bus
);

  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam int DW = $clog2(SCLK_DIV);
  localparam int XW = $clog2(X_RES + 1);
  localparam int YW = $clog2(Y_RES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(SCLK_DIV - 1);
  localparam logic [7:0]    CMD_X      = 8'hD0;
  localparam logic [7:0]    CMD_Y      = 8'h90;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t      state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [DW-1:0] div_cnt, div_next;
  logic [5:0]  period, period_next;
  logic [14:0] shreg, shreg_next;
  logic [11:0] raw_x, raw_x_next, raw_y, raw_y_next;
  logic        cs_n, cs_n_next, sclk, sclk_next, mosi, mosi_next;
  logic [11:0] x_out, x_next, y_out, y_next;
  logic        valid, valid_next, active, active_next;
  logic [1:0]  pen_sync;
  logic        pen_down;

  logic [11:0]      rx, ry, scaled_x, scaled_y;
  logic [12+XW-1:0] prod_x;
  logic [12+YW-1:0] prod_y;

  // Period indices 0..7 carry the X command, 24..31 the Y command, MSB first.
  function automatic logic cmd_bit(input logic [5:0] p);
    logic b;
    b = 1'b0;
    if (p < 6'd8)
      b = CMD_X[~p[2:0]];
    else if (p >= 6'd24 && p < 6'd32)
      b = CMD_Y[~p[2:0]];
    return b;
  endfunction

  function automatic logic is_read(input logic [5:0] p);
    return (p >= 6'd8 && p < 6'd24) || (p >= 6'd32);
  endfunction

  assign pen_down = ~pen_sync[1];

  assign rx       = (X_INVERT != 0) ? ~raw_x : raw_x;
  assign ry       = (Y_INVERT != 0) ? ~raw_y : raw_y;
  assign prod_x   = {{XW{1'b0}}, rx} * (12+XW)'(X_RES);
  assign prod_y   = {{YW{1'b0}}, ry} * (12+YW)'(Y_RES);
  assign scaled_x = 12'(prod_x >> 12);
  assign scaled_y = 12'(prod_y >> 12);

  always_ff @(posedge tft_clk) begin
    if (!rstb) begin
      state    <= IDLE;
      timer    <= '0;
      div_cnt  <= '0;
      period   <= '0;
      shreg    <= '0;
      raw_x    <= '0;
      raw_y    <= '0;
      cs_n     <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      x_out    <= '0;
      y_out    <= '0;
      valid    <= 1'b0;
      active   <= 1'b0;
      pen_sync <= 2'b11;
    end else begin
      state    <= state_next;
      timer    <= timer_next;
      div_cnt  <= div_next;
      period   <= period_next;
      shreg    <= shreg_next;
      raw_x    <= raw_x_next;
      raw_y    <= raw_y_next;
      cs_n     <= cs_n_next;
      sclk     <= sclk_next;
      mosi     <= mosi_next;
      x_out    <= x_next;
      y_out    <= y_next;
      valid    <= valid_next;
      active   <= active_next;
      pen_sync <= {pen_sync[0], bus.penirq_n};
    end
  end

  // Every SPI pin and result is computed here and registered above, so outputs are glitch-free.
  always_comb begin
    state_next  = state;
    timer_next  = timer;
    div_next    = div_cnt;
    period_next = period;
    shreg_next  = shreg;
    raw_x_next  = raw_x;
    raw_y_next  = raw_y;
    cs_n_next   = cs_n;
    sclk_next   = sclk;
    mosi_next   = mosi;
    x_next      = x_out;
    y_next      = y_out;
    valid_next  = 1'b0;
    active_next = active;
    case (state)
      IDLE: begin
        if (timer == TIMER_LAST) begin
          timer_next = '0;
          if (pen_down) begin
            state_next  = SETUP;
            cs_n_next   = 1'b0;
            sclk_next   = 1'b0;
            mosi_next   = cmd_bit(6'd0);
            div_next    = '0;
            period_next = '0;
            shreg_next  = '0;
          end else begin
            active_next = 1'b0;
          end
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      SETUP: begin
        if (div_cnt == DIV_LAST) begin
          div_next   = '0;
          sclk_next  = 1'b1;
          state_next = SHIFT;
        end else begin
          div_next = div_cnt + DW'(1);
        end
      end
      SHIFT: begin
        if (div_cnt != DIV_LAST) begin
          div_next = div_cnt + DW'(1);
        end else begin
          div_next = '0;
          if (sclk) begin
            sclk_next = 1'b0;
            mosi_next = cmd_bit(period + 6'd1);
            if (period == 6'd23)
              raw_x_next = shreg[14:3];
          end else if (period == 6'd47) begin
            state_next = HOLD;
            raw_y_next = shreg[14:3];
          end else begin
            // The busy bit falls off the top of the 15-bit register after 16 shifts.
            period_next = period + 6'd1;
            sclk_next   = 1'b1;
            if (is_read(period + 6'd1))
              shreg_next = {shreg[13:0], bus.spi_miso};
          end
        end
      end
      HOLD: begin
        if (div_cnt == DIV_LAST) begin
          div_next   = '0;
          cs_n_next  = 1'b1;
          state_next = DONE;
        end else begin
          div_next = div_cnt + DW'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
        timer_next = '0;
        if (pen_down) begin
          x_next      = scaled_x;
          y_next      = scaled_y;
          valid_next  = 1'b1;
          active_next = 1'b1;
        end else begin
          active_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.spi_cs_n     = cs_n;
  assign bus.spi_sclk     = sclk;
  assign bus.spi_mosi     = mosi;
  assign bus.touch_x      = x_out;
  assign bus.touch_y      = y_out;
  assign bus.touch_valid  = valid;
  assign bus.touch_active = active;

endmodule
